// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - register map, control bits, command and state encodings for timer_ctrl_master
package timer_ctrl_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    typedef enum logic [1:0] {
        OP_ARM  = 2'd0,
        OP_STOP = 2'd1,
        OP_SNAP = 2'd2,
        OP_RSVD = 2'd3
    } cmd_op_e;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTL,
        WAIT_TO,
        CLR_TO,
        WR_STOP,
        WR_SNAP,
        RD_SL,
        RD_SH,
        CAP_SH
`ifdef TIMER_CTRL_MASTER_POLL_EN
        ,
        POLL_A,
        POLL_C
`endif
    } state_e;

    function automatic logic [15:0] ctl_word(input logic start, input logic stop,
                                             input logic cont, input logic ito);
        logic [15:0] w;
        w            = 16'h0000;
        w[CTL_ITO]   = ito;
        w[CTL_CONT]  = cont;
        w[CTL_START] = start;
        w[CTL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// rtl/timer_ctrl_master.sv - Avalon-MM initiator arming, stopping and snapshotting the interval timer
// Optional TIMER_CTRL_MASTER_POLL_EN: poll the status register instead of using irq.
module timer_ctrl_master
    import timer_ctrl_pkg::*;
#(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              armed,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [15:0]       writedata,
    input  logic [15:0]       readdata,
    input  logic              irq
);

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    logic                cont_q, cont_d;
    logic [31:0]         period_q, period_d;
    logic                armed_q, armed_d;
    logic [TICK_W-1:0]   tick_count_q, tick_count_d;
    logic [15:0]         snap_lo_q, snap_lo_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                cs_q, cs_d;
    logic                write_n_q, write_n_d;
    logic [2:0]          addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                timeout_pend;
    logic                accept;

`ifdef TIMER_CTRL_MASTER_POLL_EN
    localparam logic ITO_EN = 1'b0;
    assign timeout_pend = 1'b0;
`else
    localparam logic ITO_EN = 1'b1;
    assign timeout_pend = irq;
`endif

    assign cmd_ready  = (state_q == IDLE) || ((state_q == WAIT_TO) && !timeout_pend);
    assign accept     = cmd_valid && cmd_ready;
    assign tick       = (state_q == CLR_TO);
    assign rsp_valid  = (state_q == CAP_SH);
    // The high half arrives during CAP_SH, so the response bypasses the holding register that cycle.
    assign rsp_data   = (state_q == CAP_SH) ? {readdata, snap_lo_q} : rsp_data_q;
    assign tick_count = tick_count_q;
    assign armed      = armed_q;
    assign address    = addr_q;
    assign chipselect = cs_q;
    assign write_n    = write_n_q;
    assign writedata  = wdata_q;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cont_d       = cont_q;
        period_d     = period_q;
        armed_d      = armed_q;
        tick_count_d = tick_count_q;
        snap_lo_d    = snap_lo_q;
        rsp_data_d   = rsp_data_q;

        case (state_q)
            IDLE, WAIT_TO: begin
                if ((state_q == WAIT_TO) && timeout_pend) begin
                    state_d = CLR_TO;
                end else if (accept && (cmd_op_e'(cmd_op) != OP_RSVD)) begin
                    case (cmd_op_e'(cmd_op))
                        OP_ARM: begin
                            state_d  = WR_PL;
                            period_d = cmd_period;
                            cont_d   = cmd_continuous;
                        end
                        OP_STOP: state_d = WR_STOP;
                        default: begin
                            state_d = WR_SNAP;
                            ret_d   = state_q;
                        end
                    endcase
`ifdef TIMER_CTRL_MASTER_POLL_EN
                end else if (state_q == WAIT_TO) begin
                    state_d = POLL_A;
`endif
                end
            end
            WR_PL:   state_d = WR_PH;
            WR_PH:   state_d = WR_CTL;
            WR_CTL: begin
                state_d = WAIT_TO;
                armed_d = 1'b1;
            end
            CLR_TO: begin
                tick_count_d = tick_count_q + TICK_W'(1);
                if (cont_q) begin
                    state_d = WAIT_TO;
                end else begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end
            end
            WR_STOP: begin
                state_d = IDLE;
                armed_d = 1'b0;
            end
            WR_SNAP: state_d = RD_SL;
            RD_SL:   state_d = RD_SH;
            RD_SH: begin
                state_d   = CAP_SH;
                snap_lo_d = readdata;
            end
            CAP_SH: begin
                state_d    = ret_q;
                rsp_data_d = {readdata, snap_lo_q};
            end
`ifdef TIMER_CTRL_MASTER_POLL_EN
            POLL_A:  state_d = POLL_C;
            POLL_C:  state_d = readdata[0] ? CLR_TO : WAIT_TO;
`endif
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered from the next state so each state owns exactly its own bus cycle.
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = 3'd0;
        wdata_d   = 16'h0000;
        case (state_d)
            WR_PL: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_PERIODL; wdata_d = period_d[15:0];
            end
            WR_PH: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_PERIODH; wdata_d = period_d[31:16];
            end
            WR_CTL: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_CONTROL;
                wdata_d = ctl_word(1'b1, 1'b0, cont_d, ITO_EN);
            end
            CLR_TO: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_STATUS;
            end
            WR_STOP: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_CONTROL;
                wdata_d = ctl_word(1'b0, 1'b1, 1'b0, 1'b0);
            end
            WR_SNAP: begin
                cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_SNAPL;
            end
            RD_SL: begin
                cs_d = 1'b1; addr_d = ADDR_SNAPL;
            end
            RD_SH: begin
                cs_d = 1'b1; addr_d = ADDR_SNAPH;
            end
`ifdef TIMER_CTRL_MASTER_POLL_EN
            POLL_A: begin
                cs_d = 1'b1; addr_d = ADDR_STATUS;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ret_q        <= IDLE;
            cont_q       <= 1'b0;
            period_q     <= 32'h0;
            armed_q      <= 1'b0;
            tick_count_q <= '0;
            snap_lo_q    <= 16'h0;
            rsp_data_q   <= 32'h0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            addr_q       <= 3'd0;
            wdata_q      <= 16'h0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cont_q       <= cont_d;
            period_q     <= period_d;
            armed_q      <= armed_d;
            tick_count_q <= tick_count_d;
            snap_lo_q    <= snap_lo_d;
            rsp_data_q   <= rsp_data_d;
            cs_q         <= cs_d;
            write_n_q    <= write_n_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb/tb_timer_ctrl_master.sv - directed bench for timer_ctrl_master against an interval-timer slave model
module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic        cmd_continuous;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tick;
    logic [15:0] tick_count;
    logic        armed;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    timer_ctrl_master #(.TICK_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tick(tick), .tick_count(tick_count), .armed(armed),
        .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval-timer slave model
    logic [15:0] t_pl, t_ph;
    logic [31:0] t_cnt, t_snap;
    logic        t_to, t_run, t_ito, t_cont;
    logic        t_wr, t_stop_wr;
    assign t_wr      = chipselect && !write_n;
    assign t_stop_wr = t_wr && (address == 3'd1) && writedata[3];
    assign irq       = t_to && t_ito;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_pl <= 16'h0; t_ph <= 16'h0; t_cnt <= 32'h0; t_snap <= 32'h0;
            t_to <= 1'b0; t_run <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
            readdata <= 16'h0;
        end else begin
            if (t_run && !t_stop_wr) begin
                if (t_cnt == 32'h0) begin
                    t_to  <= 1'b1;
                    t_cnt <= {t_ph, t_pl};
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 32'h1;
                end
            end
            if (t_wr) begin
                case (address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= writedata[0];
                        t_cont <= writedata[1];
                        if (writedata[2]) begin
                            t_run <= 1'b1;
                            t_cnt <= {t_ph, t_pl};
                        end
                        if (writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: t_pl <= writedata;
                    3'd3: t_ph <= writedata;
                    3'd4, 3'd5: t_snap <= t_cnt;
                    default: ;
                endcase
            end
            if (chipselect && write_n) begin
                case (address)
                    3'd0:    readdata <= {14'h0, t_run, t_to};
                    3'd4:    readdata <= t_snap[15:0];
                    3'd5:    readdata <= t_snap[31:16];
                    default: readdata <= 16'h0;
                endcase
            end
        end
    end

    logic [18:0] wr_log[$];
    always @(negedge clk) begin
        if (chipselect && !write_n) wr_log.push_back({address, writedata});
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont);
        bit ok = 1'b0;
        cmd_op = op; cmd_period = per; cmd_continuous = cont; cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(ok), 32'd1);
    endtask

    int          lat, nt, prev, n0;
    bit          bad_int, armed_lost, extra, busy;
    logic [15:0] base;
    logic [31:0] snap_v;

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = 32'h0; cmd_continuous = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp", {rsp_valid, rsp_data[30:0]}, 32'd0);
        check("rst_tick_armed", {tick, armed, tick_count}, 32'd0);
        check("rst_bus", {chipselect, write_n, address, writedata}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0});
        reset_n = 1'b1;
        @(negedge clk);

        // ARM period 49 one-shot
        send_cmd(2'd0, 32'd49, 1'b0);
        check("os_armed_wr_pl", 32'(armed), 32'd0);
        repeat (2) @(negedge clk);
        check("os_wr_ctl_bus", {chipselect, write_n, address, writedata}, {1'b1, 1'b0, 3'd1, 16'h0005});
        check("os_armed_wr_ctl", 32'(armed), 32'd0);
        @(negedge clk);
        check("os_armed_after_ctl", 32'(armed), 32'd1);
        check("os_wr0", 32'(wr_log.size() > 0 ? wr_log[0] : 19'h7FFFF), {13'd0, 3'd2, 16'h0031});
        check("os_wr1", 32'(wr_log.size() > 1 ? wr_log[1] : 19'h7FFFF), {13'd0, 3'd3, 16'h0000});
        check("os_wr2", 32'(wr_log.size() > 2 ? wr_log[2] : 19'h7FFFF), {13'd0, 3'd1, 16'h0005});
        lat = 4;
        while (!tick && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("os_tick_seen", 32'(tick), 32'd1);
        check("os_tick_latency_50_60", 32'(lat >= 50 && lat <= 60), 32'd1);
        check("os_clr_bus", {chipselect, write_n, address, writedata}, {1'b1, 1'b0, 3'd0, 16'h0000});
        @(negedge clk);
        check("os_after", {tick, armed, tick_count}, {14'd0, 1'b0, 1'b0, 16'd1});

        // ARM period 9 continuous, observe 100 cycles
        send_cmd(2'd0, 32'd9, 1'b1);
        repeat (3) @(negedge clk);
        base = tick_count; nt = 0; prev = -1; bad_int = 1'b0; armed_lost = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!armed) armed_lost = 1'b1;
            if (tick) begin
                if (prev >= 0 && (cyc - prev) != 10) bad_int = 1'b1;
                prev = cyc;
                nt++;
            end
        end
        check("cont_tick_n_9_10", 32'(nt == 9 || nt == 10), 32'd1);
        check("cont_tick_count", 32'(tick_count - base), 32'(nt));
        check("cont_interval_10", 32'(bad_int), 32'd0);
        check("cont_armed_held", 32'(armed_lost), 32'd0);

        // STOP during continuous run
        send_cmd(2'd1, 32'h0, 1'b0);
        check("stop_bus", {chipselect, write_n, address, writedata}, {1'b1, 1'b0, 3'd1, 16'h0008});
        @(negedge clk);
        check("stop_armed", 32'(armed), 32'd0);
        extra = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick) extra = 1'b1;
        end
        check("stop_no_tick", 32'(extra), 32'd0);

        // SNAP while armed with period 0x0001_0000
        send_cmd(2'd0, 32'h0001_0000, 1'b1);
        repeat (8) @(negedge clk);
        send_cmd(2'd2, 32'h0, 1'b0);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("snap_latency", 32'(lat), 32'd4);
        check("snap_upper", 32'(rsp_data[31:16]), 32'h0);
        check("snap_range", 32'(rsp_data <= 32'h0001_0000 && rsp_data > 32'h0000_FF00), 32'd1);
        snap_v = rsp_data;
        @(negedge clk);
        check("snap_single_pulse", 32'(rsp_valid), 32'd0);
        check("snap_held", rsp_data, snap_v);
        check("snap_back_wait_to", {armed, cmd_ready}, 32'h3);

        // timeout and SNAP in the same cycle
        send_cmd(2'd0, 32'd9, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (irq) break;
            @(negedge clk);
        end
        check("coll_irq_seen", 32'(irq), 32'd1);
        check("coll_ready_low", 32'(cmd_ready), 32'd0);
        base = tick_count;
        n0 = wr_log.size();
        send_cmd(2'd2, 32'h0, 1'b0);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("coll_rsp_seen", 32'(rsp_valid), 32'd1);
        check("coll_one_tick", 32'(tick_count - base), 32'd1);
        check("coll_first_wr", 32'(wr_log.size() > n0 ? wr_log[n0] : 19'h7FFFF), {13'd0, 3'd0, 16'h0000});
        check("coll_second_wr", 32'(wr_log.size() > n0 + 1 ? wr_log[n0 + 1] : 19'h7FFFF), {13'd0, 3'd4, 16'h0000});

        // tick_count wrap
        send_cmd(2'd1, 32'h0, 1'b0);
        @(negedge clk);
        force dut.tick_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.tick_count_q;
        check("wrap_preload", 32'(tick_count), 32'hFFFF);
        send_cmd(2'd0, 32'd3, 1'b0);
        lat = 1;
        while (!tick && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("wrap_tick_seen", 32'(tick), 32'd1);
        @(negedge clk);
        check("wrap_count", {armed, tick_count}, 32'h0);

        // reset in the middle of an ARM sequence
        send_cmd(2'd0, 32'd100, 1'b0);
        @(negedge clk);
        check("rst_mid_bus_busy", {chipselect, address}, {28'd0, 1'b1, 3'd3});
        reset_n = 1'b0;
        #1;
        check("rst_mid_bus", {chipselect, write_n, address, writedata}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0});
        check("rst_mid_status", {cmd_ready, armed, tick, rsp_valid}, 32'h8);
        check("rst_mid_rsp_data", rsp_data, 32'h0);
        check("rst_mid_tick_count", 32'(tick_count), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (chipselect) busy = 1'b1;
        end
        check("rst_mid_quiet", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
